// File: rtl/glb_stream_writer.sv
// ---------------------------------------------------------------------------
// glb_stream_writer
//
// Streams words from a local word memory over a ready/valid interface.
// Software first loads the memory through the cfg write port. A start pulse
// then streams tx_size words, beginning at base_addr, with NUM_LANES words
// per beat. Addresses wrap modulo DEPTH. When the last beat is accepted the
// block raises done and holds it until the next start or reset.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cfg_wr_en/addr/data memory write port (ignored while streaming)
//   start               transfer request; base_addr and tx_size are sampled
//                       on the same cycle
//   data, keep, valid   output beat; lane i is data[i*DATA_WIDTH +: DATA_WIDTH]
//   ready               downstream accept
//   done                level, set after the final accept (or at once for
//                       tx_size == 0)
//   busy                high while streaming
//   last                final-beat flag, present only when the macro
//                       GLB_STREAM_LAST_EN is defined
// ---------------------------------------------------------------------------
module glb_stream_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int NUM_LANES  = 1,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int TX_W       = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_wr_en,
    input  logic [ADDR_W-1:0]               cfg_wr_addr,
    input  logic [DATA_WIDTH-1:0]           cfg_wr_data,
    input  logic                            start,
    input  logic [ADDR_W-1:0]               base_addr,
    input  logic [TX_W-1:0]                 tx_size,
    output logic [NUM_LANES*DATA_WIDTH-1:0] data,
    output logic [NUM_LANES-1:0]            keep,
    output logic                            valid,
    input  logic                            ready,
    output logic                            done,
    output logic                            busy
`ifdef GLB_STREAM_LAST_EN
    ,
    output logic                            last
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                          state_reg;
    logic [DATA_WIDTH-1:0]           mem [DEPTH];
    logic [ADDR_W-1:0]               addr_reg;
    logic [TX_W-1:0]                 rem_reg;
    logic [NUM_LANES*DATA_WIDTH-1:0] data_reg;
    logic [NUM_LANES-1:0]            keep_reg;
    logic                            valid_reg;
    logic                            done_reg;

    logic                            cfg_ok;
    logic                            start_ok;
    logic                            accept;
    logic                            more;
    logic [ADDR_W-1:0]               fetch_addr;
    logic [TX_W-1:0]                 fetch_rem;
    logic [NUM_LANES*DATA_WIDTH-1:0] fetch_data;
    logic [NUM_LANES-1:0]            fetch_keep;

    // Writes are locked out while streaming so a transfer sees a stable image.
    assign cfg_ok   = cfg_wr_en && (state_reg != S_STREAM);
    assign start_ok = start && (state_reg != S_STREAM);
    assign accept   = valid_reg && ready;
    assign more     = rem_reg > TX_W'(NUM_LANES);

    // The beat being loaded next: either the first beat of a new transfer or
    // the one following the beat currently accepted.
    assign fetch_addr = start_ok ? base_addr : addr_reg + ADDR_W'(NUM_LANES);
    assign fetch_rem  = start_ok ? tx_size   : rem_reg - TX_W'(NUM_LANES);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [ADDR_W-1:0] lane_addr;
            logic              lane_fwd;

            assign lane_addr      = fetch_addr + ADDR_W'(gi);
            // A write landing in the same cycle as start must be visible in
            // the first beat, so forward it around the memory.
            assign lane_fwd       = cfg_ok && (cfg_wr_addr == lane_addr);
            assign fetch_keep[gi] = fetch_rem > TX_W'(gi);
            assign fetch_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                !fetch_keep[gi] ? '0 :
                lane_fwd        ? cfg_wr_data : mem[lane_addr];
        end
    endgenerate

`ifdef GLB_STREAM_LAST_EN
    logic last_reg;
    logic fetch_last;
    assign fetch_last = fetch_rem <= TX_W'(NUM_LANES);
    assign last       = last_reg;
`endif

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            mem[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            rem_reg   <= '0;
            data_reg  <= '0;
            keep_reg  <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
`ifdef GLB_STREAM_LAST_EN
            last_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        addr_reg <= base_addr;
                        rem_reg  <= tx_size;
                        if (tx_size == '0) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_STREAM;
                            done_reg  <= 1'b0;
                            data_reg  <= fetch_data;
                            keep_reg  <= fetch_keep;
                            valid_reg <= 1'b1;
`ifdef GLB_STREAM_LAST_EN
                            last_reg  <= fetch_last;
`endif
                        end
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        if (more) begin
                            addr_reg <= fetch_addr;
                            rem_reg  <= fetch_rem;
                            data_reg <= fetch_data;
                            keep_reg <= fetch_keep;
`ifdef GLB_STREAM_LAST_EN
                            last_reg <= fetch_last;
`endif
                        end else begin
                            state_reg <= S_DONE;
                            rem_reg   <= '0;
                            data_reg  <= '0;
                            keep_reg  <= '0;
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
`ifdef GLB_STREAM_LAST_EN
                            last_reg  <= 1'b0;
`endif
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign data  = data_reg;
    assign keep  = keep_reg;
    assign valid = valid_reg;
    assign done  = done_reg;
    assign busy  = (state_reg == S_STREAM);

endmodule

// File: tb/tb_glb_stream_writer.sv
// ---------------------------------------------------------------------------
// tb_glb_stream_writer
//
// Two instances share every input: one with a single lane, one with four
// lanes. A memory image kept in the bench plus a per-beat rule
// (lane i of beat k = mem[(base + k*lanes + i) mod DEPTH] when the word index
// is below tx, else zero) provides every expected value.
// ---------------------------------------------------------------------------
module tb_glb_stream_writer;

    localparam int DW    = 16;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int TXW   = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_wr_en = 1'b0;
    logic [AW-1:0]   cfg_wr_addr = '0;
    logic [DW-1:0]   cfg_wr_data = '0;
    logic            start = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic [TXW-1:0]  tx_size = '0;
    logic            ready = 1'b0;

    logic [DW-1:0]   data1;
    logic [0:0]      keep1;
    logic            valid1, done1, busy1, last1;
    logic [4*DW-1:0] data4;
    logic [3:0]      keep4;
    logic            valid4, done4, busy4, last4;

    always #5 clk = ~clk;

    glb_stream_writer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_LANES(1), .TX_W(TXW)) dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data), .start(start), .base_addr(base_addr), .tx_size(tx_size),
        .data(data1), .keep(keep1), .valid(valid1), .ready(ready), .done(done1), .busy(busy1)
`ifdef GLB_STREAM_LAST_EN
        , .last(last1)
`endif
    );

    glb_stream_writer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_LANES(4), .TX_W(TXW)) dut4 (
        .clk(clk), .rst_n(rst_n), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data), .start(start), .base_addr(base_addr), .tx_size(tx_size),
        .data(data4), .keep(keep4), .valid(valid4), .ready(ready), .done(done4), .busy(busy4)
`ifdef GLB_STREAM_LAST_EN
        , .last(last4)
`endif
    );

`ifndef GLB_STREAM_LAST_EN
    assign last1 = 1'b0;
    assign last4 = 1'b0;
`endif

    logic [DW-1:0] ref_mem [DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int base;
        int tx;
        int mode;       // 0: ready always high, 1: ready 1,0,0,1 pattern, 2: random
        int beats1;     // accepts expected from the 1-lane instance
        int beats4;     // accepts expected from the 4-lane instance
        bit wr_start;   // cfg write to base in the start cycle
        bit inject;     // start pulse and cfg write in the middle of streaming
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void exp_beat(input int nl, input int base, input int tx, input int k,
                                     output logic [63:0] d, output logic [7:0] kp);
        d  = '0;
        kp = '0;
        for (int i = 0; i < nl; i++) begin
            int idx;
            idx = k * nl + i;
            if (idx < tx) begin
                kp[i] = 1'b1;
                d[i*DW +: DW] = ref_mem[(base + idx) % DEPTH];
            end
        end
    endfunction

    task automatic check_dut(input string tag, input int nl, input int base, input int tx,
                             input int nbeats, input logic v, input logic b, input logic dn,
                             input logic [63:0] d, input logic [7:0] kp, input logic lst,
                             input logic rdy, inout int k);
        logic        exp_v;
        logic [63:0] ed;
        logic [7:0]  ek;
        exp_v = (k < nbeats);
        check({tag, " valid"}, {63'b0, v}, {63'b0, exp_v});
        check({tag, " busy"},  {63'b0, b}, {63'b0, exp_v});
        check({tag, " done"},  {63'b0, dn}, {63'b0, !exp_v});
        if (exp_v && v) begin
            exp_beat(nl, base, tx, k, ed, ek);
            check({tag, " data"}, d, ed);
            check({tag, " keep"}, {56'b0, kp}, {56'b0, ek});
`ifdef GLB_STREAM_LAST_EN
            check({tag, " last"}, {63'b0, lst}, {63'b0, (k == nbeats - 1)});
`else
            if (lst !== 1'b0) check({tag, " last"}, {63'b0, lst}, 64'd0);
`endif
            if (rdy) k++;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " valid1"}, {63'b0, valid1}, 64'd0);
        check({tag, " done1"},  {63'b0, done1},  64'd0);
        check({tag, " busy1"},  {63'b0, busy1},  64'd0);
        check({tag, " data1"},  {48'b0, data1},  64'd0);
        check({tag, " keep1"},  {63'b0, keep1},  64'd0);
        check({tag, " valid4"}, {63'b0, valid4}, 64'd0);
        check({tag, " done4"},  {63'b0, done4},  64'd0);
        check({tag, " busy4"},  {63'b0, busy4},  64'd0);
        check({tag, " data4"},  data4,           64'd0);
        check({tag, " keep4"},  {60'b0, keep4},  64'd0);
    endtask

    // Called just after a posedge with both instances outside STREAM.
    task automatic run_xfer(input vec_t v);
        int nb1, nb4, k1, k4, a1, a4, extra, budget;
        bit finished;
        int pat [4] = '{1, 0, 0, 1};
        nb1 = v.tx;
        nb4 = (v.tx + 3) / 4;
        if (v.wr_start) begin
            logic [DW-1:0] w;
            w = DW'($urandom);
            ref_mem[v.base % DEPTH] = w;
            cfg_wr_en   = 1'b1;
            cfg_wr_addr = AW'(v.base);
            cfg_wr_data = w;
        end
        start     = 1'b1;
        base_addr = AW'(v.base);
        tx_size   = TXW'(v.tx);
        @(posedge clk); #1;
        start = 1'b0;
        cfg_wr_en = 1'b0;
        k1 = 0; k4 = 0; a1 = 0; a4 = 0; extra = 0; finished = 0;
        budget = nb1 * 4 + 20;
        for (int c = 0; c < budget; c++) begin
            case (v.mode)
                0:       ready = 1'b1;
                1:       ready = pat[c % 4][0];
                default: ready = 1'($urandom_range(0, 1));
            endcase
            if (v.inject && c == 3) begin
                start       = 1'b1;
                base_addr   = AW'(5);
                tx_size     = TXW'(3);
                cfg_wr_en   = 1'b1;
                cfg_wr_addr = AW'((v.base + 5) % DEPTH);
                cfg_wr_data = ~ref_mem[(v.base + 5) % DEPTH];
            end
            @(negedge clk);
            if (valid1 && ready) a1++;
            if (valid4 && ready) a4++;
            check_dut("lane1", 1, v.base, v.tx, nb1, valid1, busy1, done1, {48'b0, data1},
                      {7'b0, keep1}, last1, ready, k1);
            check_dut("lane4", 4, v.base, v.tx, nb4, valid4, busy4, done4, data4,
                      {4'b0, keep4}, last4, ready, k4);
            @(posedge clk); #1;
            start = 1'b0;
            cfg_wr_en = 1'b0;
            if (k1 >= nb1 && k4 >= nb4) extra++;
            if (extra >= 3) begin
                finished = 1;
                break;
            end
        end
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: base=%0d tx=%0d got beats %0d/%0d expected %0d/%0d",
                     v.base, v.tx, k1, k4, nb1, nb4);
        end
        check("accepts lane1", 64'(a1), 64'(v.beats1));
        check("accepts lane4", 64'(a4), 64'(v.beats4));
        $display("xfer base=%0d tx=%0d mode=%0d accepts=%0d/%0d", v.base, v.tx, v.mode, a1, a4);
    endtask

    vec_t vecs [8];

    initial begin
        int k1, k4;
        vecs[0] = '{base: 0,    tx: 32, mode: 0, beats1: 32, beats4: 8, wr_start: 0, inject: 0};
        vecs[1] = '{base: 0,    tx: 8,  mode: 1, beats1: 8,  beats4: 2, wr_start: 0, inject: 0};
        vecs[2] = '{base: 0,    tx: 10, mode: 0, beats1: 10, beats4: 3, wr_start: 0, inject: 0};
        vecs[3] = '{base: 1022, tx: 4,  mode: 0, beats1: 4,  beats4: 1, wr_start: 0, inject: 0};
        vecs[4] = '{base: 0,    tx: 0,  mode: 0, beats1: 0,  beats4: 0, wr_start: 0, inject: 0};
        vecs[5] = '{base: 1020, tx: 13, mode: 2, beats1: 13, beats4: 4, wr_start: 0, inject: 0};
        vecs[6] = '{base: 200,  tx: 4,  mode: 0, beats1: 4,  beats4: 1, wr_start: 1, inject: 0};
        vecs[7] = '{base: 0,    tx: 40, mode: 0, beats1: 40, beats4: 10, wr_start: 0, inject: 1};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Preload the memory image
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]  = (i < 32) ? DW'(16'h100 + i) : DW'($urandom);
            cfg_wr_en   = 1'b1;
            cfg_wr_addr = AW'(i);
            cfg_wr_data = ref_mem[i];
            @(posedge clk); #1;
        end
        cfg_wr_en = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 8; t++) run_xfer(vecs[t]);

        // Random transfers
        for (int r = 0; r < 6; r++) begin
            vec_t rv;
            rv.base     = int'($urandom_range(0, DEPTH - 1));
            rv.tx       = int'($urandom_range(0, 24));
            rv.mode     = 2;
            rv.beats1   = rv.tx;
            rv.beats4   = (rv.tx + 3) / 4;
            rv.wr_start = 1'($urandom_range(0, 1));
            rv.inject   = 0;
            run_xfer(rv);
        end

        // Reset after three accepted beats of a 16-word transfer
        start = 1'b1; base_addr = AW'(0); tx_size = TXW'(16); ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k1 = 0; k4 = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_dut("rst lane1", 1, 0, 16, 16, valid1, busy1, done1, {48'b0, data1},
                      {7'b0, keep1}, last1, ready, k1);
            check_dut("rst lane4", 4, 0, 16, 4, valid4, busy4, done4, data4,
                      {4'b0, keep4}, last4, ready, k4);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        $display("reset after 3 beats: valid=%0d/%0d done=%0d/%0d", valid1, valid4, done1, done4);
        @(posedge clk); #1;
        run_xfer('{base: 100, tx: 2, mode: 0, beats1: 2, beats4: 1, wr_start: 0, inject: 0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
